mem_port_arbiter: RTL

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester. Selects one owner per transaction and registers that owner's address, write data and byte enables onto the memory port. It then returns the read data and a one-cycle done pulse to that owner. Data accesses have priority over fetches, and a starvation guard guarantees that fetches still make forward progress.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);
  localparam logic [CntW-1:0] LimitVal = CntW'(LIMIT);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LimitVal)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign at_limit = (cnt_q == LimitVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, data first,
// with a starvation guard that forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_t state_q;
  owner_t     owner_q;
  logic       at_limit;
  logic       grant_d;
  logic       grant_if;
  logic       cnt_inc;
  logic       cnt_clr;

  // Data wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    grant_d  = d_req && !(if_req && at_limit);
    grant_if = if_req && !grant_d;
    cnt_inc  = (state_q == IDLE) && grant_d && if_req;
    cnt_clr  = (state_q == IDLE) && (grant_if || (grant_d && !if_req));
  end

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q   <= GRANT_D;
            owner_q   <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (grant_if) begin
            state_q   <= GRANT_IF;
            owner_q   <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
          end
        end
        GRANT_IF, GRANT_D: begin
          if (mem_ack) begin
            state_q <= RESP;
            mem_req <= 1'b0;
            if (owner_q == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              d_done <= 1'b1;
              // Stores keep the last load result visible.
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
